// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and types for the 32 x 32 register file and
//            the blocks that sit on its write port.
// Contents : XLEN, REG_AW, NUM_REGS, REG_X0, reg_addr_t, xlen_t
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_addr_t REG_X0 = 5'd0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched_if
// Purpose  : Bundle of every non-clock signal of the register-file write-port
//            scheduler: pipeline writeback, long-latency handshake, issue
//            and hazard-check operands, and the register file write port.
// Modports : master - environment side (pipeline, long-latency unit, issue
//                     stage, register file)
//            slave  - scheduler side
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_sched_if;
  import regfile_pkg::*;

  // pipeline writeback
  logic      core_we;
  reg_addr_t core_rd;
  xlen_t     core_wdata;
  logic      core_hold;
  // long-latency unit
  logic      ext_valid;
  reg_addr_t ext_rd;
  xlen_t     ext_wdata;
  logic      ext_ready;
  // issue stage
  logic      iss_valid;
  logic      iss_long;
  reg_addr_t iss_rd;
  reg_addr_t chk_rs1;
  reg_addr_t chk_rs2;
  reg_addr_t chk_rd;
  logic      stall;
  // register file write port 3
  logic      rf_we;
  reg_addr_t rf_waddr;
  xlen_t     rf_wdata;

  modport master (
    output core_we, core_rd, core_wdata,
    output ext_valid, ext_rd, ext_wdata,
    output iss_valid, iss_long, iss_rd, chk_rs1, chk_rs2, chk_rd,
    input  core_hold, ext_ready, stall, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  core_we, core_rd, core_wdata,
    input  ext_valid, ext_rd, ext_wdata,
    input  iss_valid, iss_long, iss_rd, chk_rs1, chk_rs2, chk_rd,
    output core_hold, ext_ready, stall, rf_we, rf_waddr, rf_wdata
  );

endinterface : regfile_wb_sched_if
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Pending-write scoreboard for long-latency destinations x1..x31
//            and the hazard lookup that drives the issue-stage stall.
// Ports    : clk, rst_n            - clock, async active-low reset
//            set_en / set_addr     - mark a destination pending
//            clr_en / clr_addr     - long-latency write retired
//            chk_rs1/chk_rs2/chk_rd- operands of the instruction in issue
//            hazard                - any operand has a pending write
// Options  : REGFILE_WB_BYPASS_EN - a retiring write is not a hazard for
//            rs1/rs2 in its own cycle (register file forwards the write).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t chk_rs1,
  input  reg_addr_t chk_rs2,
  input  reg_addr_t chk_rd,
  output logic      hazard
);

  // x0 has no storage; the lookup vector carries a constant 0 in its place
  logic [NUM_REGS-1:1] pending;
  logic [NUM_REGS-1:0] pending_lookup;
  logic                rs1_bypass;
  logic                rs2_bypass;

  assign pending_lookup = {pending, 1'b0};

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_pending_bit
    // set is tested first so a same-cycle issue to the retiring register
    // keeps the bit pending for the newer write
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pending[i] <= 1'b0;
      end else if (set_en && (set_addr == REG_AW'(i))) begin
        pending[i] <= 1'b1;
      end else if (clr_en && (clr_addr == REG_AW'(i))) begin
        pending[i] <= 1'b0;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // source operands can read the retiring value through register file
  // forwarding; the destination check stays conservative for WAW ordering
  assign rs1_bypass = clr_en && (clr_addr == chk_rs1);
  assign rs2_bypass = clr_en && (clr_addr == chk_rs2);
`else
  assign rs1_bypass = 1'b0;
  assign rs2_bypass = 1'b0;
`endif

  assign hazard = (pending_lookup[chk_rs1] & ~rs1_bypass)
                | (pending_lookup[chk_rs2] & ~rs2_bypass)
                |  pending_lookup[chk_rd];

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Purpose  : Shares the register file's single write port between the
//            in-order pipeline writeback and a long-latency unit, bounds the
//            starvation of the long-latency unit, and tracks outstanding
//            long-latency destinations to stall dependent issue.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - regfile_wb_sched_if.slave (writeback, long-latency
//                     handshake, issue/check operands, rf write port)
// Params   : STARVE_LIMIT (1..15) - cycles a valid long-latency write may
//            lose arbitration before the pipeline is held off.
// Options  : REGFILE_WB_BYPASS_EN - see regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_sched_if.slave  bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;
  logic       ext_fire;
  logic       core_grant;
  logic       iss_set;

  // Arbitration: the pipeline normally wins; once the long-latency unit has
  // lost STARVE_MAX times in a row the pipeline is held for one cycle.
  assign starved       = (starve_cnt == STARVE_MAX);
  assign bus.core_hold = bus.ext_valid & starved;
  assign bus.ext_ready = bus.ext_valid & (~bus.core_we | bus.core_hold);
  assign ext_fire      = bus.ext_valid & bus.ext_ready;
  assign core_grant    = bus.core_we & ~bus.core_hold;

  // A core write presented while held is dropped here by construction.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = REG_X0;
    bus.rf_wdata = '0;
    if (ext_fire) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.ext_rd;
      bus.rf_wdata = bus.ext_wdata;
    end else if (core_grant) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.core_rd;
      bus.rf_wdata = bus.core_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (bus.ext_valid && !bus.ext_ready) begin
      if (!starved) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  assign iss_set = bus.iss_valid & bus.iss_long & (bus.iss_rd != REG_X0);

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_set),
    .set_addr (bus.iss_rd),
    .clr_en   (ext_fire),
    .clr_addr (bus.ext_rd),
    .chk_rs1  (bus.chk_rs1),
    .chk_rs2  (bus.chk_rs2),
    .chk_rd   (bus.chk_rd),
    .hazard   (bus.stall)
  );

endmodule : regfile_wb_sched
`default_nettype wire

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the 32×32 register file. It shares the file's single write port between two sources: the in-order pipeline writeback and a long-latency unit (load/divide) with a valid/ready handshake. It also tracks destinations with long-latency writes outstanding, and tells the issue stage when it must stall. The block sits between the writeback stage, the long-latency unit and the register file write port (`we`/`waddr`/`wdata`).

## Interface
Parameters:
- `STARVE_LIMIT`, default 4. Maximum number of consecutive cycles a valid long-latency write may lose arbitration. Legal range is 1..15.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `core_we` in 1: pipeline writeback request.
- `core_rd` in 5: pipeline destination register.
- `core_wdata` in 32: pipeline write data.
- `core_hold` out 1: pipeline must not write this cycle (`core_we` must be 0).
- `ext_valid` in 1: long-latency result is valid.
- `ext_rd` in 5: long-latency destination register.
- `ext_wdata` in 32: long-latency write data.
- `ext_ready` out 1: long-latency result accepted this cycle.
- `iss_valid` in 1: an instruction issues this cycle.
- `iss_long` in 1: the issuing instruction writes via the long-latency unit.
- `iss_rd` in 5: destination of the issuing instruction.
- `chk_rs1`, `chk_rs2`, `chk_rd` in 5 each: operands of the instruction in the issue stage.
- `stall` out 1: a hazard exists against a pending long-latency write.
- `rf_we` out 1: to the register file `write_en_3`.
- `rf_waddr` out 5: to the register file `write_addr_3`.
- `rf_wdata` out 32: to the register file `write_data_3`.

## Operation
- State:
  - `pending[31:1]` scoreboard. Bit 0 does not exist; x0 is never pending.
  - `starve_cnt` saturating counter, 4 bits.
- Derived signals:
  - `starved = (starve_cnt == STARVE_LIMIT)`.
  - `core_hold = ext_valid & starved`.
- Arbitration:
  - `ext_ready = ext_valid & (~core_we | core_hold)`.
  - Handshake: `ext_fire = ext_valid & ext_ready`.
- Write-port mux:
  - If `ext_fire`: `rf_we=1`, `rf_waddr=ext_rd`, `rf_wdata=ext_wdata`.
  - Else if `core_we & ~core_hold`: `rf_we=1`, `rf_waddr=core_rd`, `rf_wdata=core_wdata`.
  - Else: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`.
- Contract violation: `core_we=1` while `core_hold=1` drops the core write. This is flagged by a bench assertion only.
- Starvation counter:
  - Increments (saturating at `STARVE_LIMIT`) when `ext_valid & ~ext_ready`.
  - Clears to 0 on `ext_fire` or when `ext_valid=0`.
- Scoreboard:
  - Set `pending[iss_rd]` when `iss_valid & iss_long & iss_rd!=0`.
  - Clear `pending[ext_rd]` on `ext_fire`.
  - Set and clear of the same bit in the same cycle: set wins.
- Stall:
  - `stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]`, with x0 reading as 0.
  - The `chk_rd` term covers WAW hazards.
  - The issue stage drives `iss_valid` only when `stall=0`. The block does not check this.
- Reset: `pending=0` and `starve_cnt=0`, so `core_hold=0`, `stall=0`, and `ext_ready`/`rf_*` depend only on the inputs.
  - Reset asserted mid-handshake discards all pending state.
  - The long-latency unit must also be reset.

## Timing
- The write path is combinational, with zero cycles from request to `rf_*`. The register file commits on the next `clk` edge.
- A scoreboard set is visible on `stall` the cycle after issue.
- A scoreboard clear is visible the cycle after `ext_fire`; see Configuration for the same-cycle bypass.
- Worst-case wait for a long-latency write with `core_we` held high every cycle:
  - It is rejected for exactly `STARVE_LIMIT` cycles.
  - It is granted in cycle `STARVE_LIMIT`, counting from 0 as the first valid cycle.
- `core_hold` is high for exactly the grant cycle.
- `ext_valid`, `ext_rd` and `ext_wdata` must be held stable until `ext_fire`.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined:
  - The `rs1`/`rs2` stall terms exclude `ext_rd` when `ext_fire` is high in the same cycle. This relies on the register file's same-cycle write forwarding.
  - The `chk_rd` term is not bypassed.
- Not defined: `stall` uses the registered `pending` only, so a dependent instruction waits one extra cycle.

## Structure
- Shared package `regfile_pkg` holds:
  - `XLEN=32`, `REG_AW=5`, `NUM_REGS=32`, `REG_X0=5'd0`.
  - Typedefs `reg_addr_t` and `xlen_t`.
- Sub-module `regfile_scoreboard` contains the pending vector, set/clear logic, hazard lookup and the bypass option.
- The top level keeps the arbiter, the starvation counter and the write mux.

## Test plan
- Reset scenario:
  - Stimulus: `rst_n=0`, then release.
  - Response: `stall=0`, `core_hold=0`, `rf_we=0`.
  - Then apply `core_we=1`, `core_rd=3`, `core_wdata=0x11`: `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x11` the same cycle.
- Scoreboard scenario:
  - Issue long with `iss_rd=5`; the next cycle `chk_rs1=5` gives `stall=1`.
  - `ext_fire` with `ext_rd=5`: `stall=0` the next cycle, or the same cycle with `REGFILE_WB_BYPASS_EN`.
- Starvation scenario:
  - `STARVE_LIMIT=4`, `core_we=1` every cycle, `ext_valid=1` from cycle 0.
  - Cycles 0–3: `ext_ready=0`.
  - Cycle 4: `core_hold=1`, `ext_ready=1`, `rf_waddr=ext_rd`.
  - Cycle 5: `core_hold=0`.
- x0 scenario:
  - Issue long with `iss_rd=0`: `pending` stays 0.
  - `chk_rs1=0` never stalls.
- Simultaneous set/clear scenario:
  - `ext_fire` with `ext_rd=7` and long issue with `iss_rd=7` in the same cycle.
  - `pending[7]=1` afterwards, and `stall=1` for `chk_rd=7`.
- Mid-operation reset scenario:
  - Assert `rst_n=0` while `starve_cnt=3` and `pending[9]=1`.
  - `core_hold=0` and `stall=0` immediately (asynchronous), and they stay 0 after release.
